// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared state type, default sizes and address-width helper for the filter datapath
package filter_pkg;

  localparam int DEF_N_TAPS = 4;
  localparam int DEF_COEF_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    STREAM
  } filt_state_t;

  function automatic int addr_w(input int n_taps);
    return (n_taps > 1) ? $clog2(n_taps) : 1;
  endfunction

endpackage

// File: rtl/filter_coef_bank.sv
// rtl/filter_coef_bank.sv - shadow coefficient register file, one write port, one async read port
module filter_coef_bank
  import filter_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter logic [N_TAPS*COEF_W-1:0] DEF_COEFS = '0,
  localparam int ADDR_W = addr_w(N_TAPS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [COEF_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [COEF_W-1:0] rdata_o
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] N_TAPS_L = AW1'(N_TAPS);

  logic [COEF_W-1:0] mem [N_TAPS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < N_TAPS; i++) begin
        mem[i] <= DEF_COEFS[i*COEF_W +: COEF_W];
      end
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Unused index codes (non power-of-two tap counts) read as zero
  assign rdata_o = ({1'b0, raddr_i} < N_TAPS_L) ? mem[raddr_i] : '0;

endmodule

// File: rtl/filter_coef_loader.sv
// rtl/filter_coef_loader.sv - host coefficient writes, commit-driven filter reset hold and h0..h(N-1) stream
// Optional AUTO_LOAD_EN: stream the default bank automatically after reset release.
module filter_coef_loader
  import filter_pkg::*;
#(
  parameter int N_TAPS = DEF_N_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int RST_CYCLES = 10,
  parameter logic [N_TAPS*COEF_W-1:0] DEF_COEFS = 32'h04030201,
  localparam int ADDR_W = addr_w(N_TAPS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [COEF_W-1:0] wr_data_i,
  input  logic              commit_i,
  output logic              busy_o,
  output logic              filt_rst_o,
  output logic [COEF_W-1:0] coef_o,
  output logic              coef_valid_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_TAPS - 1);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] N_TAPS_L = AW1'(N_TAPS);

  filt_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              loaded, loaded_nxt;
  logic              auto_go;
  logic              wr_fire, bank_we;
  logic [COEF_W-1:0] bank_rdata;
  logic              wr_ready_nxt, busy_nxt, filt_rst_nxt, coef_valid_nxt, done_nxt, err_nxt;
  logic [COEF_W-1:0] coef_nxt;

  filter_coef_bank #(
    .N_TAPS   (N_TAPS),
    .COEF_W   (COEF_W),
    .DEF_COEFS(DEF_COEFS)
  ) u_bank (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .we_i   (bank_we),
    .waddr_i(wr_addr_i),
    .wdata_i(wr_data_i),
    .raddr_i(idx_nxt),
    .rdata_o(bank_rdata)
  );

`ifdef AUTO_LOAD_EN
  logic auto_pending;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      auto_pending <= 1'b1;
    end else if (state == IDLE) begin
      auto_pending <= 1'b0;
    end
  end

  assign auto_go = auto_pending;
`else
  assign auto_go = 1'b0;
`endif

  assign wr_fire = wr_valid_i & wr_ready_o;
  assign bank_we = wr_fire & ({1'b0, wr_addr_i} < N_TAPS_L);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      loaded       <= 1'b0;
      wr_ready_o   <= 1'b0;
      busy_o       <= 1'b0;
      filt_rst_o   <= 1'b1;
      coef_o       <= '0;
      coef_valid_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      loaded       <= loaded_nxt;
      wr_ready_o   <= wr_ready_nxt;
      busy_o       <= busy_nxt;
      filt_rst_o   <= filt_rst_nxt;
      coef_o       <= coef_nxt;
      coef_valid_o <= coef_valid_nxt;
      done_o       <= done_nxt;
      err_o        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    idx_nxt        = idx;
    loaded_nxt     = loaded;
    wr_ready_nxt   = 1'b0;
    busy_nxt       = 1'b0;
    filt_rst_nxt   = 1'b1;
    coef_nxt       = '0;
    coef_valid_nxt = 1'b0;
    done_nxt       = 1'b0;
    err_nxt        = err_o | (wr_fire & ~bank_we);

    case (state)
      IDLE: begin
        if (commit_i || auto_go) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_LAST) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STREAM: begin
        if (idx == IDX_LAST) begin
          state_nxt  = IDLE;
          loaded_nxt = 1'b1;
          done_nxt   = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they land in the register this edge
    case (state_nxt)
      IDLE: begin
        wr_ready_nxt = 1'b1;
        filt_rst_nxt = ~loaded_nxt;
      end
      HOLD: begin
        busy_nxt = 1'b1;
      end
      STREAM: begin
        busy_nxt       = 1'b1;
        filt_rst_nxt   = 1'b0;
        coef_nxt       = bank_rdata;
        coef_valid_nxt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_filter_coef_loader.sv
// tb/tb_filter_coef_loader.sv - scoreboard bench: directed load sequences, random traffic, out-of-range write check
module tb_filter_coef_loader;

  localparam int N = 4;
  localparam int W = 8;
  localparam int R = 10;
  localparam logic [31:0] DEF = 32'h04030201;

  logic       clk = 1'b0;
  logic       reset_i, wr_valid_i, commit_i;
  logic [1:0] wr_addr_i;
  logic [7:0] wr_data_i;
  logic       wr_ready_o, busy_o, filt_rst_o, coef_valid_o, done_o, err_o;
  logic [7:0] coef_o;

  logic       reset_b, wr_valid_b, commit_b;
  logic [1:0] wr_addr_b;
  logic [7:0] wr_data_b;
  logic       wr_ready_b, busy_b, filt_rst_b, coef_valid_b, done_b, err_b;
  logic [7:0] coef_b;

  always #5 clk = ~clk;

  filter_coef_loader #(.N_TAPS(N), .COEF_W(W), .RST_CYCLES(R), .DEF_COEFS(DEF)) dut (
    .clk_i(clk), .reset_i(reset_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .commit_i(commit_i), .busy_o(busy_o),
    .filt_rst_o(filt_rst_o), .coef_o(coef_o), .coef_valid_o(coef_valid_o), .done_o(done_o),
    .err_o(err_o)
  );

  filter_coef_loader #(.N_TAPS(3), .COEF_W(8), .RST_CYCLES(2), .DEF_COEFS(24'h0C0B0A)) dut3 (
    .clk_i(clk), .reset_i(reset_b), .wr_valid_i(wr_valid_b), .wr_ready_o(wr_ready_b),
    .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b), .commit_i(commit_b), .busy_o(busy_b),
    .filt_rst_o(filt_rst_b), .coef_o(coef_b), .coef_valid_o(coef_valid_b), .done_o(done_b),
    .err_o(err_b)
  );

  typedef struct {
    int         e;
    logic [7:0] v;
  } exp_t;

  exp_t       exp_q[$];
  int         done_q[$];
  logic [7:0] obs[$];
  logic [7:0] obs3[$];
  logic [7:0] ref_bank[N];
  logic [31:0] def_bits;
  int  tests = 0, fails = 0;
  int  edge_cnt = 0, reset_at = -10, last_k = 0, done_seen = 0;
  bit  have_k = 0, ref_err = 0, model_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: a load accepted at edge k owns the block until edge k+R+N
  always @(posedge clk) begin
    edge_cnt++;
    if (reset_i) begin
      reset_at = edge_cnt;
      have_k   = 0;
      ref_err  = 0;
      def_bits = DEF;
      for (int i = 0; i < N; i++) ref_bank[i] = def_bits[i*W +: W];
      exp_q.delete();
      done_q.delete();
    end else begin
      model_idle = !have_k || (edge_cnt >= last_k + R + N + 1);
      if (wr_valid_i && model_idle && (reset_at != edge_cnt - 1)) begin
        if (wr_addr_i < N) ref_bank[wr_addr_i] = wr_data_i;
        else ref_err = 1;
      end
      if (commit_i && model_idle) begin
        last_k = edge_cnt;
        have_k = 1;
        for (int i = 0; i < N; i++) exp_q.push_back('{edge_cnt + R + i, ref_bank[i]});
        done_q.push_back(edge_cnt + R + N);
      end
    end
  end

  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      int e, ph;
      exp_t it;
      e = edge_cnt;
      if (reset_at == e) begin
        chk("rst_wr_ready", wr_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_filt_rst", filt_rst_o, 1);
        chk("rst_err", err_o, 0);
      end else begin
        ph = !have_k ? 0 : (e < last_k + R) ? 1 : (e < last_k + R + N) ? 2 : 0;
        chk("wr_ready", wr_ready_o, ph == 0);
        chk("busy", busy_o, ph != 0);
        chk("filt_rst", filt_rst_o, (ph == 1) ? 1 : (ph == 2) ? 0 : !have_k);
        chk("err", err_o, ref_err);
      end
      if (coef_valid_o) begin
        obs.push_back(coef_o);
        if (exp_q.size() == 0) chk("coef_valid", coef_valid_o, 0);
        else begin
          it = exp_q.pop_front();
          chk("coef_edge", e, it.e);
          chk("coef_value", coef_o, it.v);
        end
      end else begin
        chk("coef_idle_zero", coef_o, 0);
        while (exp_q.size() > 0 && exp_q[0].e <= e) begin
          chk("coef_valid", coef_valid_o, 1);
          void'(exp_q.pop_front());
        end
      end
      if (done_o) begin
        done_seen++;
        if (done_q.size() == 0) chk("done", done_o, 0);
        else chk("done_edge", e, done_q.pop_front());
      end else begin
        while (done_q.size() > 0 && done_q[0] <= e) begin
          chk("done", done_o, 1);
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic commit_pulse();
    commit_i = 1;
    tick(1);
    commit_i = 0;
  endtask

  task automatic chk_obs4(input string name, input logic [7:0] a, b, c, d);
    chk({name, "_len"}, obs.size(), 4);
    if (obs.size() == 4) begin
      chk({name, "_h0"}, obs[0], a);
      chk({name, "_h1"}, obs[1], b);
      chk({name, "_h2"}, obs[2], c);
      chk({name, "_h3"}, obs[3], d);
    end
    obs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1; wr_valid_i = 0; commit_i = 0; wr_addr_i = 0; wr_data_i = 0;
    reset_b = 1; wr_valid_b = 0; commit_b = 0; wr_addr_b = 0; wr_data_b = 0;
    tick(3);
    reset_i = 0;

    // 1: default bank
    tick(4);
    obs.delete(); done_seen = 0;
    commit_pulse();
    tick(R + N + 2);
    chk_obs4("t1", 8'h01, 8'h02, 8'h03, 8'h04);
    chk("t1_done_count", done_seen, 1);

    // 2: host writes then commit
    wr_valid_i = 1; wr_addr_i = 0; wr_data_i = 8'h10; tick(1);
    wr_addr_i = 3; wr_data_i = 8'hA5; tick(1);
    wr_valid_i = 0;
    commit_pulse();
    tick(R + N + 2);
    chk_obs4("t2", 8'h10, 8'h02, 8'h03, 8'hA5);
    chk("t2_filt_rst_low", filt_rst_o, 0);

    // 3: write and commit on the same edge
    wr_valid_i = 1; wr_addr_i = 2; wr_data_i = 8'h7F; commit_i = 1;
    tick(1);
    wr_valid_i = 0; commit_i = 0;
    tick(R + N + 2);
    chk_obs4("t3", 8'h10, 8'h02, 8'h7F, 8'hA5);

    // 5: write stalled during HOLD, commit ignored during STREAM
    done_seen = 0;
    commit_pulse();
    tick(2);
    wr_valid_i = 1; wr_addr_i = 1; wr_data_i = 8'h33;
    tick(R - 1);
    commit_pulse();
    @(negedge clk);
    for (int n = 0; n < 100 && !wr_ready_o; n++) @(negedge clk);
    chk("t5_ready_seen", wr_ready_o, 1);
    @(posedge clk); #1;
    wr_valid_i = 0;
    tick(R + N + 4);
    chk("t5_done_count", done_seen, 1);
    chk_obs4("t5a", 8'h10, 8'h02, 8'h7F, 8'hA5);
    commit_pulse();
    tick(R + N + 2);
    chk_obs4("t5b", 8'h10, 8'h33, 8'h7F, 8'hA5);

    // 6: reset during the second streamed coefficient aborts the load
    commit_pulse();
    tick(R + 1);
    reset_i = 1;
    tick(1);
    reset_i = 0;
    chk("t6_filt_rst", filt_rst_o, 1);
    chk("t6_coef_valid", coef_valid_o, 0);
    chk("t6_partial_len", obs.size(), 2);
    obs.delete();
    tick(2);
    commit_pulse();
    tick(R + N + 2);
    chk_obs4("t6", 8'h01, 8'h02, 8'h03, 8'h04);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      reset_i    = ($urandom_range(0, 199) == 0);
      wr_valid_i = ($urandom_range(0, 2) == 0);
      wr_addr_i  = 2'($urandom_range(0, 3));
      wr_data_i  = 8'($urandom);
      commit_i   = ($urandom_range(0, 14) == 0);
      tick(1);
    end
    reset_i = 0; wr_valid_i = 0; commit_i = 0;
    tick(R + N + 3);
    chk("drain_coef_q", exp_q.size(), 0);
    chk("drain_done_q", done_q.size(), 0);

    // 4: out-of-range address on a 3-tap instance
    reset_b = 0;
    tick(1);
    chk("t4_err_init", err_b, 0);
    wr_valid_b = 1; wr_addr_b = 3; wr_data_b = 8'hEE;
    tick(1);
    chk("t4_err_set", err_b, 1);
    wr_addr_b = 1; wr_data_b = 8'h55;
    tick(1);
    wr_valid_b = 0;
    chk("t4_err_sticky", err_b, 1);
    commit_b = 1;
    tick(1);
    commit_b = 0;
    for (int c = 0; c < 10; c++) begin
      if (coef_valid_b) obs3.push_back(coef_b);
      tick(1);
    end
    chk("t4_len", obs3.size(), 3);
    if (obs3.size() == 3) begin
      chk("t4_h0", obs3[0], 8'h0A);
      chk("t4_h1", obs3[1], 8'h55);
      chk("t4_h2", obs3[2], 8'h0C);
    end
    chk("t4_err_after_stream", err_b, 1);
    reset_b = 1;
    tick(1);
    reset_b = 0;
    chk("t4_err_cleared", err_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
